// File: rtl/csr_bram_loader_pkg.sv
// Shared definitions for the CSR automaton table loader and its readers.
// Holds the BRAM geometry, the header tag value and field positions, and the
// loader state encoding.
package csr_bram_loader_pkg;

   localparam int         CSR_ADDR_W  = 20;
   localparam int         CSR_DATA_W  = 32;
   localparam logic [7:0] CSR_MAGIC   = 8'hC5;

   // Header word layout: tag in [31:24], word count in [ADDR_W-1:0]
   localparam int         HDR_TAG_MSB = 31;
   localparam int         HDR_TAG_LSB = 24;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_HDR  = 3'd1;
   localparam state_t ST_LOAD = 3'd2;
   localparam state_t ST_DONE = 3'd3;
   localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/csr_bram_loader_if.sv
// Stream-in / BRAM-write-out bundle for csr_bram_loader.
//  s_data, s_valid : word stream from the source
//  s_ready         : loader accepts the word this cycle
//  wr_addr, wr_data, wr_en : BRAM write port
// slave  = loader side, master = stream source / BRAM side.
interface csr_bram_loader_if
   import csr_bram_loader_pkg::*;
#(
   parameter int ADDR_W = CSR_ADDR_W,
   parameter int DATA_W = CSR_DATA_W
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;

   modport slave (
      input  s_data, s_valid,
      output s_ready, wr_addr, wr_data, wr_en
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, wr_addr, wr_data, wr_en
   );
endinterface

// File: rtl/csr_bram_loader_hdr_check.sv
// Combinational header decode for the table loader.
//  hdr     in   DATA_W  candidate header word
//  ok      out  1       tag matches and the table fits above BASE_ADDR
//  n_words out  ADDR_W  word count field
module csr_bram_loader_hdr_check
   import csr_bram_loader_pkg::*;
#(
   parameter int               ADDR_W    = CSR_ADDR_W,
   parameter int               DATA_W    = CSR_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [7:0]        MAGIC     = CSR_MAGIC
) (
   input  logic [DATA_W-1:0] hdr,
   output logic              ok,
   output logic [ADDR_W-1:0] n_words
);
   localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] end_addr;
   logic            tag_ok;
   logic            range_ok;
   logic            unused_hdr_bits;

   // Bits between the count field and the tag carry no meaning
   assign unused_hdr_bits = ^hdr[HDR_TAG_LSB-1:ADDR_W];

   always_comb begin
      n_words  = hdr[ADDR_W-1:0];
      // One extra bit so BASE_ADDR + N can reach exactly 2**ADDR_W without wrapping
      end_addr = {1'b0, BASE_ADDR} + {1'b0, n_words};
      tag_ok   = (hdr[HDR_TAG_MSB:HDR_TAG_LSB] == MAGIC);
      range_ok = (end_addr <= ADDR_SPAN);
      ok       = tag_ok && range_ok;
   end
endmodule

// File: rtl/csr_bram_loader.sv
// Writer side of the CSR automaton table memory. Parses one header word from
// the stream, then writes N table words to the BRAM at consecutive addresses
// starting at BASE_ADDR. load_done gates traversal start.
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-low
//  start      in   1         one-cycle pulse; arms the loader from IDLE, DONE or ERR
//  bus        slave          stream in + BRAM write port (csr_bram_loader_if)
//  load_busy  out  1         header or table load in progress
//  load_done  out  1         table valid; held until next start or reset
//  load_error out  1         bad tag or range overflow; held until next start or reset
//  words_wr   out  ADDR_W+1  words written during the current load
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | waiting to accept the header word
// LOAD  | accepting table words, one BRAM write per accept
// DONE  | table complete (also the cycle of the final write)
// ERR   | header rejected, no writes
module csr_bram_loader
   import csr_bram_loader_pkg::*;
#(
   parameter int               ADDR_W    = CSR_ADDR_W,
   parameter int               DATA_W    = CSR_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [7:0]        MAGIC     = CSR_MAGIC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   csr_bram_loader_if.slave   bus,
   output logic               load_busy,
   output logic               load_done,
   output logic               load_error,
   output logic [ADDR_W:0]    words_wr
);
   state_t            state;
   logic [ADDR_W-1:0] remaining;
   logic              accept;
   logic              hdr_ok;
   logic [ADDR_W-1:0] hdr_n;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   csr_bram_loader_hdr_check #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (BASE_ADDR),
      .MAGIC     (MAGIC)
   ) u_hdr_check (
      .hdr     (bus.s_data),
      .ok      (hdr_ok),
      .n_words (hdr_n)
   );

   assign load_busy   = (state == ST_HDR) || (state == ST_LOAD);
   assign bus.s_ready = load_busy;
   assign accept      = bus.s_valid && load_busy;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         remaining  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         words_wr   <= '0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               // DONE is entered with the final write; done shows one cycle later
               if (state == ST_DONE) begin
                  load_done <= 1'b1;
               end
               if (start) begin
                  state      <= ST_HDR;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
                  words_wr   <= '0;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  if (!hdr_ok) begin
                     state      <= ST_ERR;
                     load_error <= 1'b1;
                  end else if (hdr_n == '0) begin
                     state <= ST_DONE;
                  end else begin
                     remaining <= hdr_n;
                     state     <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= bus.s_data;
                  wr_addr_q <= BASE_ADDR + words_wr[ADDR_W-1:0];
                  words_wr  <= words_wr + (ADDR_W+1)'(1);
                  remaining <= remaining - ADDR_W'(1);
                  if (remaining == ADDR_W'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_bram_loader.sv
// Directed bench for csr_bram_loader: dut0 at base 0, dut1 at base 20'hFFFFE.
module tb_csr_bram_loader;
   import csr_bram_loader_pkg::*;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   always #5 clk = ~clk;

   csr_bram_loader_if bus0 ();
   csr_bram_loader_if bus1 ();

   logic        busy0, done0, err0, busy1, done1, err1;
   logic [20:0] ww0, ww1;

   csr_bram_loader #(.BASE_ADDR(20'h00000)) dut0 (
      .clk(clk), .reset(rst_n), .start(start0), .bus(bus0.slave),
      .load_busy(busy0), .load_done(done0), .load_error(err0), .words_wr(ww0)
   );

   csr_bram_loader #(.BASE_ADDR(20'hFFFFE)) dut1 (
      .clk(clk), .reset(rst_n), .start(start1), .bus(bus1.slave),
      .load_busy(busy1), .load_done(done1), .load_error(err1), .words_wr(ww1)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [19:0] q_addr0[$];
   logic [31:0] q_data0[$];
   int          q_cyc0[$];
   logic [19:0] q_addr1[$];
   logic [31:0] q_data1[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus0.wr_en === 1'b1) begin
         q_addr0.push_back(bus0.wr_addr);
         q_data0.push_back(bus0.wr_data);
         q_cyc0.push_back(cyc);
      end
      if (bus1.wr_en === 1'b1) begin
         q_addr1.push_back(bus1.wr_addr);
         q_data1.push_back(bus1.wr_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      q_addr0.delete(); q_data0.delete(); q_cyc0.delete();
      q_addr1.delete(); q_data1.delete();
   endtask

   task automatic chk_zero0(input string p);
      chk({p, "_s_ready"}, bus0.s_ready, 0);
      chk({p, "_wr_en"},   bus0.wr_en,   0);
      chk({p, "_wr_addr"}, bus0.wr_addr, 0);
      chk({p, "_wr_data"}, bus0.wr_data, 0);
      chk({p, "_busy"},    busy0,        0);
      chk({p, "_done"},    done0,        0);
      chk({p, "_error"},   err0,         0);
      chk({p, "_words"},   ww0,          0);
   endtask

   task automatic pulse(input int which);
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Offers one word and returns at the negedge after it was accepted
   task automatic send(input int which, input logic [31:0] d);
      int   n;
      logic rdy;
      n = 0;
      if (which == 0) begin bus0.s_data = d; bus0.s_valid = 1'b1; end
      else            begin bus1.s_data = d; bus1.s_valid = 1'b1; end
      rdy = (which == 0) ? bus0.s_ready : bus1.s_ready;
      while (rdy !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
         rdy = (which == 0) ? bus0.s_ready : bus1.s_ready;
      end
      chk("send_ready", rdy, 1);
      @(negedge clk);
      if (which == 0) begin bus0.s_valid = 1'b0; bus0.s_data = 'x; end
      else            begin bus1.s_valid = 1'b0; bus1.s_data = 'x; end
   endtask

   initial begin
      logic [31:0] w2 [3];
      logic [31:0] w6 [5];
      w2 = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
      w6 = '{32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003, 32'h6000_0004};
      bus0.s_valid = 1'b0; bus0.s_data = 'x;
      bus1.s_valid = 1'b0; bus1.s_data = 'x;

      // 1: reset, then back-to-back load of three words
      repeat (3) @(negedge clk);
      chk_zero0("rst");
      chk("rst_dut1_ready", bus1.s_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
      pulse(0);
      chk("t1_busy_hdr", busy0, 1);
      send(0, 32'hC500_0003);
      send(0, 32'hAAAA_0001);
      send(0, 32'hBBBB_0002);
      send(0, 32'hCCCC_0003);
      chk("t1_ready_after_last", bus0.s_ready, 0);
      @(negedge clk);
      chk("t1_nwrites", q_addr0.size(), 3);
      if (q_addr0.size() == 3) begin
         chk("t1_addr0", q_addr0[0], 20'h0);
         chk("t1_addr1", q_addr0[1], 20'h1);
         chk("t1_addr2", q_addr0[2], 20'h2);
         chk("t1_data0", q_data0[0], 32'hAAAA_0001);
         chk("t1_data1", q_data0[1], 32'hBBBB_0002);
         chk("t1_data2", q_data0[2], 32'hCCCC_0003);
         chk("t1_consec01", q_cyc0[1] - q_cyc0[0], 1);
         chk("t1_consec12", q_cyc0[2] - q_cyc0[1], 1);
      end
      chk("t1_done",  done0, 1);
      chk("t1_words", ww0,   3);
      chk("t1_busy",  busy0, 0);
      chk("t1_err",   err0,  0);

      // 2: same load with a bubble after every word
      clear_logs();
      pulse(0);
      chk("t2_done_cleared",  done0, 0);
      chk("t2_words_cleared", ww0,   0);
      send(0, 32'hC500_0003);
      for (int i = 0; i < 3; i++) begin
         send(0, w2[i]);
         chk($sformatf("t2_wren_%0d", i), bus0.wr_en,   1);
         chk($sformatf("t2_addr_%0d", i), bus0.wr_addr, i);
         chk($sformatf("t2_data_%0d", i), bus0.wr_data, w2[i]);
         @(negedge clk);
         chk($sformatf("t2_gap_wren_%0d", i), bus0.wr_en, 0);
      end
      chk("t2_nwrites", q_addr0.size(), 3);
      chk("t2_done",    done0, 1);
      chk("t2_words",   ww0,   3);

      // 3: bad tag, stream held valid, then a good reload
      clear_logs();
      pulse(0);
      send(0, 32'hA100_0004);
      chk("t3_err",   err0,         1);
      chk("t3_ready", bus0.s_ready, 0);
      bus0.s_valid = 1'b1;
      bus0.s_data  = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      bus0.s_valid = 1'b0;
      bus0.s_data  = 'x;
      chk("t3_nowrites", q_addr0.size(), 0);
      chk("t3_err_held", err0, 1);
      chk("t3_done_low", done0, 0);
      pulse(0);
      chk("t3_err_cleared", err0, 0);
      send(0, 32'hC500_0002);
      send(0, 32'h0000_0011);
      send(0, 32'h0000_0022);
      @(negedge clk);
      chk("t3_done",     done0, 1);
      chk("t3_nwrites",  q_addr0.size(), 2);
      if (q_data0.size() == 2) begin
         chk("t3_data1", q_data0[1], 32'h0000_0022);
         chk("t3_addr1", q_addr0[1], 20'h1);
      end

      // 4: top-of-memory range check on dut1
      clear_logs();
      pulse(1);
      send(1, 32'hC500_0003);
      chk("t4_overflow_err", err1, 1);
      chk("t4_overflow_ready", bus1.s_ready, 0);
      pulse(1);
      send(1, 32'hC500_0002);
      send(1, 32'h0000_0033);
      send(1, 32'h0000_0044);
      @(negedge clk);
      chk("t4_nwrites", q_addr1.size(), 2);
      if (q_addr1.size() == 2) begin
         chk("t4_addr0", q_addr1[0], 20'hFFFFE);
         chk("t4_addr1", q_addr1[1], 20'hFFFFF);
         chk("t4_data0", q_data1[0], 32'h0000_0033);
         chk("t4_data1", q_data1[1], 32'h0000_0044);
      end
      chk("t4_done",  done1, 1);
      chk("t4_err",   err1,  0);
      chk("t4_words", ww1,   2);

      // 5: empty table
      clear_logs();
      pulse(0);
      send(0, 32'hC500_0000);
      @(negedge clk);
      chk("t5_done",    done0, 1);
      chk("t5_words",   ww0,   0);
      chk("t5_nowrite", q_addr0.size(), 0);
      chk("t5_busy",    busy0, 0);

      // 6: reset after two of five words, then a full reload
      clear_logs();
      pulse(0);
      send(0, 32'hC500_0005);
      send(0, w6[0]);
      send(0, w6[1]);
      chk("t6_wren_before_rst", bus0.wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk_zero0("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
      pulse(0);
      send(0, 32'hC500_0005);
      for (int i = 0; i < 5; i++) send(0, w6[i]);
      @(negedge clk);
      chk("t6_done",    done0, 1);
      chk("t6_words",   ww0,   5);
      chk("t6_nwrites", q_addr0.size(), 5);
      if (q_addr0.size() == 5) begin
         chk("t6_addr4", q_addr0[4], 20'h4);
         chk("t6_data4", q_data0[4], w6[4]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
